// File: rtl/sumador_restador_reg_pkg.sv
// Shared definitions for the registered adder/subtractor: operation codes,
// slice width and the arithmetic used by each 4-bit slice.
package sumador_restador_reg_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    MODO_HOLD = 2'b00,
    MODO_ADD  = 2'b01,
    MODO_SUB  = 2'b10,
    MODO_CLR  = 2'b11
  } modo_e;

  // Bit 4 of the result is the carry (add) or the borrow (subtract); the
  // 5-bit difference goes negative exactly when a < b + ci.
  function automatic logic [SLICE_W:0] slice_op(
    input logic [SLICE_W-1:0] a,
    input logic [SLICE_W-1:0] b,
    input logic               sub,
    input logic               ci
  );
    logic [SLICE_W:0] r;
    if (sub) begin
      r = {1'b0, a} - {1'b0, b} - {4'b0000, ci};
    end else begin
      r = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    end
    return r;
  endfunction

endpackage

// File: rtl/sumador_restador_4b.sv
// Combinational 4-bit adder/subtractor slice; co is carry when sub=0 and
// borrow when sub=1, so slices cascade through co -> ci.
module sumador_restador_4b
  import sumador_restador_reg_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] r_s;

  assign r_s = slice_op(a, b, sub, ci);
  assign s   = r_s[3:0];
  assign co  = r_s[4];

endmodule

// File: rtl/sumador_restador_reg.sv
// Registered N-bit adder/subtractor with hold and clear, built from cascaded
// 4-bit slices. Q/RCO are the only state and are driven straight from flops.
module sumador_restador_reg
  import sumador_restador_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       MODO,
  input  logic             ENB,
  input  logic             RCI,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_bad_width
      $error("sumador_restador_reg: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  logic [NSLICE:0]  chain_s;
  logic [WIDTH-1:0] res_s;
  logic             sub_s;
  logic [WIDTH-1:0] q_d, q_q;
  logic             rco_d, rco_q;

  assign sub_s      = (MODO == MODO_SUB);
  assign chain_s[0] = RCI;

  // Carry/borrow ripples from slice k into slice k+1 within the cycle.
  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    sumador_restador_4b u_slice (
      .a  (A[k*SLICE_W +: SLICE_W]),
      .b  (B[k*SLICE_W +: SLICE_W]),
      .sub(sub_s),
      .ci (chain_s[k]),
      .s  (res_s[k*SLICE_W +: SLICE_W]),
      .co (chain_s[k+1])
    );
  end

  // Next-state select: ENB gates everything, then MODO picks the operation.
  always_comb begin
    q_d   = q_q;
    rco_d = rco_q;
    if (ENB) begin
      case (modo_e'(MODO))
        MODO_HOLD: begin
          q_d   = q_q;
          rco_d = rco_q;
        end
        MODO_ADD, MODO_SUB: begin
          q_d   = res_s;
          rco_d = chain_s[NSLICE];
        end
        MODO_CLR: begin
          q_d   = {WIDTH{1'b0}};
          rco_d = 1'b0;
        end
        default: begin
          q_d   = q_q;
          rco_d = rco_q;
        end
      endcase
    end else begin
      q_d   = q_q;
      rco_d = rco_q;
    end
  end

  // Result and carry/borrow flops with asynchronous clear.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      q_q   <= {WIDTH{1'b0}};
      rco_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
    end
  end

  assign Q   = q_q;
  assign RCO = rco_q;

endmodule

// File: tb/tb_sumador_restador_reg.sv
// Self-checking bench: 4-bit and 8-bit instances share control inputs and are
// compared against an integer-arithmetic reference model after every edge.
module tb_sumador_restador_reg;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b1;
  logic [1:0] MODO = 2'b00;
  logic       ENB = 1'b0;
  logic       RCI = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0, q4;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, q8;
  logic       rco4, rco8;

  int unsigned st4 = 0;
  int unsigned st8 = 0;
  int n_checks = 0;
  int n_errors = 0;

  sumador_restador_reg #(.WIDTH(4)) u_dut4 (
    .CLK(CLK), .RESET_L(RESET_L), .A(a4), .B(b4), .MODO(MODO),
    .ENB(ENB), .RCI(RCI), .Q(q4), .RCO(rco4)
  );

  sumador_restador_reg #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RESET_L(RESET_L), .A(a8), .B(b8), .MODO(MODO),
    .ENB(ENB), .RCI(RCI), .Q(q8), .RCO(rco8)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: state packs {rco, q} as one integer of width w+1.
  function automatic int unsigned ref_next(input int w, input int unsigned st,
                                           input int a, input int b, input int m,
                                           input int e, input int ci);
    int modv;
    int d;
    modv = 1 << w;
    if (e == 0) return st;
    case (m)
      1: return a + b + ci;
      2: begin
        d = a - b - ci;
        if (d < 0) return modv + (d + modv);
        return d;
      end
      3: return 0;
      default: return st;
    endcase
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] a8v, input logic [7:0] b8v,
                       input logic [1:0] m, input logic e, input logic ci);
    a4 = a; b4 = b; a8 = a8v; b8 = b8v; MODO = m; ENB = e; RCI = ci;
  endtask

  task automatic tick(input string tag);
    st4 = ref_next(4, st4, a4, b4, MODO, ENB, RCI);
    st8 = ref_next(8, st8, a8, b8, MODO, ENB, RCI);
    @(posedge CLK);
    #1;
    check_val({tag, "_q4"}, q4, st4 & 32'hF);
    check_val({tag, "_rco4"}, rco4, st4 >> 4);
    check_val({tag, "_q8"}, q8, st8 & 32'hFF);
    check_val({tag, "_rco8"}, rco8, st8 >> 8);
  endtask

  initial begin
    #1 RESET_L = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("reset_q4", q4, 0);
    check_val("reset_rco4", rco4, 0);
    RESET_L = 1'b1;

    // Additions
    apply(4'b0010, 4'b0001, 8'h12, 8'h34, 2'b01, 1'b1, 1'b0); tick("add1");
    check_val("add1_spec", {rco4, q4}, 5'b00011);
    apply(4'b1111, 4'b0001, 8'hF0, 8'h0F, 2'b01, 1'b1, 1'b0); tick("add3");
    check_val("add3_spec", {rco4, q4}, 5'b10000);
    apply(4'b0111, 4'b0011, 8'h80, 8'h80, 2'b01, 1'b1, 1'b1); tick("add2");
    check_val("add2_spec", {rco4, q4}, 5'b01011);

    // Asynchronous reset with Q=1011: clears before the next edge, holds while low
    #3 RESET_L = 1'b0;
    #1;
    check_val("async_rst_q4", q4, 0);
    check_val("async_rst_rco4", rco4, 0);
    check_val("async_rst_q8", q8, 0);
    st4 = 0; st8 = 0;
    apply(4'b0101, 4'b0101, 8'h55, 8'h55, 2'b01, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    check_val("rst_held_q4", q4, 0);
    check_val("rst_held_rco4", rco4, 0);
    RESET_L = 1'b1;
    tick("post_rst");

    // Subtractions
    apply(4'b0100, 4'b0001, 8'h40, 8'h01, 2'b10, 1'b1, 1'b0); tick("sub1");
    check_val("sub1_spec", {rco4, q4}, 5'b00011);
    apply(4'b0001, 4'b0100, 8'h01, 8'h40, 2'b10, 1'b1, 1'b0); tick("sub2");
    check_val("sub2_spec", {rco4, q4}, 5'b11101);
    apply(4'b0001, 4'b0100, 8'h01, 8'h40, 2'b10, 1'b1, 1'b1); tick("sub3");
    check_val("sub3_spec", {rco4, q4}, 5'b11100);
    apply(4'b0000, 4'b0000, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1); tick("sub4");
    check_val("sub4_spec", {rco4, q4}, 5'b11111);

    // Hold via MODO with operands toggling
    apply(4'b0100, 4'b0010, 8'h04, 8'h02, 2'b01, 1'b1, 1'b0); tick("hold_setup");
    for (int i = 0; i < 3; i++) begin
      apply(4'(i * 5 + 3), 4'(i * 7 + 9), 8'(i * 33), 8'(i * 91), 2'b00, 1'b1, 1'b1);
      tick("hold_modo");
      check_val("hold_modo_spec", {rco4, q4}, 5'b00110);
    end

    // Hold via ENB, including MODO=11
    apply(4'b1001, 4'b0011, 8'h99, 8'h33, 2'b10, 1'b0, 1'b1); tick("enb0_sub");
    apply(4'b1001, 4'b0011, 8'h99, 8'h33, 2'b11, 1'b0, 1'b0); tick("enb0_clr");
    check_val("enb0_spec", {rco4, q4}, 5'b00110);
    apply(4'b1001, 4'b0011, 8'h99, 8'h33, 2'b01, 1'b1, 1'b0); tick("enb1");

    // Clear from Q=1100, RCO=1
    apply(4'b0001, 4'b0100, 8'h01, 8'h40, 2'b10, 1'b1, 1'b1); tick("clr_setup");
    apply(4'b1111, 4'b1111, 8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1); tick("clr");
    check_val("clr_spec", {rco4, q4}, 5'b00000);

    // Carry across the 8-bit slice boundary
    apply(4'b0000, 4'b0000, 8'hFF, 8'h01, 2'b01, 1'b1, 1'b0); tick("w8_carry");
    check_val("w8_carry_spec", {23'd0, rco8, q8}, 32'h100);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2 RESET_L = 1'b0;
        #1;
        check_val("rnd_rst_q8", q8, 0);
        check_val("rnd_rst_rco4", rco4, 0);
        st4 = 0; st8 = 0;
        #2 RESET_L = 1'b1;
      end
      apply(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
